// File: rtl/dense_mac_engine.sv
// dense_mac_engine
//   Computes one dense layer: for each of N_OUT neurons, the dot product of
//   the N_IN-entry activation buffer with N_IN weights streamed from an
//   upstream ShiftRAM (neuron-major order). The result is shifted down by
//   FRAC, saturated to 16 bits, optionally ReLU-clamped and offered on a
//   valid/ready output. The weight stream only advances while accumulating,
//   so output back-pressure stalls the stream.
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous reset, active low
//   start    : begin one inference (honoured in IDLE only)
//   x_we     : activation buffer write strobe (IDLE only, x_addr < N_IN)
//   x_addr   : activation index
//   x_wdata  : signed activation
//   w_en     : read-advance strobe to the weight ShiftRAM
//   w_rdata  : signed weight, valid the cycle after its w_en cycle
//   y_valid  : result available
//   y_ready  : downstream accepts result
//   y_data   : signed neuron result
//   y_idx    : neuron index of y_data
//   busy     : engine not idle
//   done     : one-cycle pulse after the last result is accepted
//
// State  | meaning
// IDLE   | waiting for start; activation writes accepted
// ACC    | streaming N_IN weights for the current neuron (w_en high)
// FLUSH  | last product accumulated, result registered
// OUT    | result offered, waiting for y_ready
// DONE   | done pulse, neuron index returns to 0

module dense_mac_engine #(
    parameter int N_IN  = 784,
    parameter int N_OUT = 200,
    parameter int FRAC  = 8,
    parameter int RELU  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        x_we,
    input  logic [9:0]  x_addr,
    input  logic [15:0] x_wdata,
    output logic        w_en,
    input  logic [15:0] w_rdata,
    output logic        y_valid,
    input  logic        y_ready,
    output logic [15:0] y_data,
    output logic [7:0]  y_idx,
    output logic        busy,
    output logic        done
);

    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IW-1:0]      I_LAST  = IW'(N_IN - 1);
    localparam logic [7:0]         Y_LAST  = 8'(N_OUT - 1);
    localparam logic [10:0]        N_IN_W  = 11'(N_IN);
    localparam logic signed [41:0] SAT_MAX = 42'sd32767;
    localparam logic signed [41:0] SAT_MIN = -42'sd32768;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_FLUSH,
        S_OUT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      i_q, i_d;
    logic signed [41:0] acc_q, acc_d;
    logic signed [15:0] x_rd_q;
    logic               mac_vld_q;
    logic [15:0]        y_data_q, y_data_d;
    logic [7:0]         y_idx_q, y_idx_d;

    logic signed [15:0] x_mem [N_IN];

    logic signed [31:0] prod;
    logic signed [41:0] acc_sum;
    logic signed [41:0] acc_shr;
    logic [15:0]        y_res;

    // Activation buffer: not reset, so a loaded vector survives an abort.
    always_ff @(posedge clk) begin
        if (x_we && (state_q == S_IDLE) && ({1'b0, x_addr} < N_IN_W)) begin
            x_mem[x_addr[IW-1:0]] <= x_wdata;
        end
    end

    // mac_vld_q marks the cycle in which x_rd_q and w_rdata belong together.
    always_comb begin
        prod    = 32'(x_rd_q) * 32'($signed(w_rdata));
        acc_sum = acc_q + (mac_vld_q ? 42'(prod) : 42'sd0);
        acc_shr = acc_sum >>> FRAC;
        if (acc_shr > SAT_MAX) begin
            y_res = 16'h7FFF;
        end else if (acc_shr < SAT_MIN) begin
            y_res = 16'h8000;
        end else begin
            y_res = acc_shr[15:0];
        end
        if ((RELU != 0) && y_res[15]) begin
            y_res = '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        acc_d    = acc_q;
        y_data_d = y_data_q;
        y_idx_d  = y_idx_q;
        w_en     = 1'b0;
        y_valid  = 1'b0;
        done     = 1'b0;
        busy     = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACC;
                    i_d     = '0;
                    acc_d   = '0;
                end
            end
            S_ACC: begin
                w_en  = 1'b1;
                acc_d = acc_sum;
                if (i_q == I_LAST) begin
                    state_d = S_FLUSH;
                    i_d     = '0;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            S_FLUSH: begin
                // Register the result from the sum that includes the last product.
                acc_d    = acc_sum;
                y_data_d = y_res;
                state_d  = S_OUT;
            end
            S_OUT: begin
                y_valid = 1'b1;
                if (y_ready) begin
                    if (y_idx_q == Y_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACC;
                        y_idx_d = y_idx_q + 8'd1;
                        i_d     = '0;
                        acc_d   = '0;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
                y_idx_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            acc_q     <= '0;
            x_rd_q    <= '0;
            mac_vld_q <= 1'b0;
            y_data_q  <= '0;
            y_idx_q   <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            acc_q     <= acc_d;
            x_rd_q    <= x_mem[i_q];
            mac_vld_q <= w_en;
            y_data_q  <= y_data_d;
            y_idx_q   <= y_idx_d;
        end
    end

    assign y_data = y_data_q;
    assign y_idx  = y_idx_q;

endmodule

// File: tb/tb_dense_mac_engine.sv
module tb_dense_mac_engine;

    localparam int NS = 4;
    localparam int OS = 2;
    localparam int NC = 32;
    localparam int OC = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, start_c, x_we, y_ready, clr;
    logic [9:0]  x_addr;
    logic [15:0] x_wdata;

    logic        a_w_en, a_y_valid, a_busy, a_done;
    logic [15:0] a_w_rdata, a_y_data;
    logic [7:0]  a_y_idx;
    logic        b_w_en, b_y_valid, b_busy, b_done;
    logic [15:0] b_w_rdata, b_y_data;
    logic [7:0]  b_y_idx;
    logic        c_w_en, c_y_valid, c_busy, c_done;
    logic [15:0] c_w_rdata, c_y_data;
    logic [7:0]  c_y_idx;

    dense_mac_engine #(.N_IN(NS), .N_OUT(OS), .FRAC(8), .RELU(0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .x_we(x_we), .x_addr(x_addr),
        .x_wdata(x_wdata), .w_en(a_w_en), .w_rdata(a_w_rdata), .y_valid(a_y_valid),
        .y_ready(y_ready), .y_data(a_y_data), .y_idx(a_y_idx), .busy(a_busy), .done(a_done));

    dense_mac_engine #(.N_IN(NS), .N_OUT(OS), .FRAC(8), .RELU(1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .x_we(x_we), .x_addr(x_addr),
        .x_wdata(x_wdata), .w_en(b_w_en), .w_rdata(b_w_rdata), .y_valid(b_y_valid),
        .y_ready(y_ready), .y_data(b_y_data), .y_idx(b_y_idx), .busy(b_busy), .done(b_done));

    dense_mac_engine #(.N_IN(NC), .N_OUT(OC), .FRAC(8), .RELU(0)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .x_we(x_we), .x_addr(x_addr),
        .x_wdata(x_wdata), .w_en(c_w_en), .w_rdata(c_w_rdata), .y_valid(c_y_valid),
        .y_ready(y_ready), .y_data(c_y_data), .y_idx(c_y_idx), .busy(c_busy), .done(c_done));

    // Weight ShiftRAM models: read pointer advances on w_en, data one cycle later.
    shortint wmem_s [NS*OS];
    shortint wmem_c [NC*OC];
    shortint xs [NS];
    shortint xc [NC];
    int pa, pb, pc, wen_a, wen_c, done_a, done_b, done_c;

    always @(posedge clk) begin
        if (clr) begin
            pa <= 0; pb <= 0; pc <= 0; wen_a <= 0; wen_c <= 0;
            done_a <= 0; done_b <= 0; done_c <= 0;
        end else begin
            if (a_w_en) begin a_w_rdata <= wmem_s[pa % (NS*OS)]; pa <= pa + 1; wen_a <= wen_a + 1; end
            if (b_w_en) begin b_w_rdata <= wmem_s[pb % (NS*OS)]; pb <= pb + 1; end
            if (c_w_en) begin c_w_rdata <= wmem_c[pc % (NC*OC)]; pc <= pc + 1; wen_c <= wen_c + 1; end
            if (a_done) done_a <= done_a + 1;
            if (b_done) done_b <= done_b + 1;
            if (c_done) done_c <= done_c + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_x(input logic [9:0] addr, input logic [15:0] data);
        x_addr = addr; x_wdata = data; x_we = 1'b1;
        tick();
        x_we = 1'b0;
    endtask

    // Reference: dot product, floor shift by 8, saturate, optional ReLU.
    function automatic logic [15:0] ref_out(input longint acc, input bit relu);
        longint s;
        s = acc >>> 8;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return 16'(s);
    endfunction

    function automatic longint dot_s(input int n);
        longint a = 0;
        for (int i = 0; i < NS; i++) a += longint'(xs[i]) * longint'(wmem_s[n*NS + i]);
        return a;
    endfunction

    function automatic longint dot_c(input int n);
        longint a = 0;
        for (int i = 0; i < NC; i++) a += longint'(xc[i]) * longint'(wmem_c[n*NC + i]);
        return a;
    endfunction

    logic [7:0]  res_idx [$];
    logic [15:0] res_a [$];
    logic [15:0] res_b [$];
    int          lat [$];
    int          gap [$];
    int          stall_err;

    task automatic run_small(input int stall, input bit busy_write);
        logic prev_wen = 1'b0;
        logic prev_valid = 1'b0;
        int acc_cyc = 0;
        int nstart = 0;
        int stalled = 0;
        logic [15:0] held = '0;
        res_idx.delete(); res_a.delete(); res_b.delete(); lat.delete(); gap.delete();
        stall_err = 0;
        clr = 1'b1; tick(); clr = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            x_we = 1'b0;
            if (busy_write && cyc == 1) begin
                x_addr = 10'd0; x_wdata = 16'h7FFF; x_we = 1'b1;
            end
            if (a_w_en && !prev_wen) begin
                nstart = cyc;
                if (res_a.size() > 0) gap.push_back(cyc - acc_cyc);
            end
            if (a_y_valid && !prev_valid) lat.push_back(cyc - nstart);
            if (a_y_valid && stalled < stall) begin
                if (stalled == 0) held = a_y_data;
                if (a_w_en || a_y_data !== held) stall_err++;
                stalled++;
                y_ready = 1'b0;
            end else begin
                y_ready = 1'b1;
            end
            if (a_y_valid && y_ready) begin
                res_idx.push_back(a_y_idx); res_a.push_back(a_y_data); res_b.push_back(b_y_data);
                acc_cyc = cyc;
            end
            prev_wen = a_w_en; prev_valid = a_y_valid;
            tick();
        end
        x_we = 1'b0;
    endtask

    task automatic check_small(input string tag);
        chk({tag, "_n_results"}, res_a.size(), OS);
        for (int n = 0; n < OS; n++) begin
            if (n < res_a.size()) begin
                chk($sformatf("%s_idx%0d", tag, n), res_idx[n], n);
                chk($sformatf("%s_a_data%0d", tag, n), res_a[n], ref_out(dot_s(n), 1'b0));
                chk($sformatf("%s_b_data%0d", tag, n), res_b[n], ref_out(dot_s(n), 1'b1));
            end
        end
        chk({tag, "_wen_total"}, wen_a, NS*OS);
        chk({tag, "_done_a"}, done_a, 1);
        chk({tag, "_done_b"}, done_b, 1);
        chk({tag, "_busy_end"}, a_busy, 1'b0);
        chk({tag, "_n_lat"}, lat.size(), OS);
        for (int n = 0; n < OS; n++) begin
            if (n < lat.size()) chk($sformatf("%s_latency%0d", tag, n), lat[n], NS + 1);
        end
        chk({tag, "_n_gap"}, gap.size(), OS - 1);
        if (gap.size() > 0) chk({tag, "_restart_gap"}, gap[0], 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_a_w_en"}, a_w_en, 1'b0);
        chk({tag, "_a_y_valid"}, a_y_valid, 1'b0);
        chk({tag, "_a_busy"}, a_busy, 1'b0);
        chk({tag, "_a_done"}, a_done, 1'b0);
        chk({tag, "_a_y_data"}, a_y_data, 16'h0000);
        chk({tag, "_a_y_idx"}, a_y_idx, 8'h00);
        chk({tag, "_b_busy"}, b_busy, 1'b0);
        chk({tag, "_b_y_data"}, b_y_data, 16'h0000);
        chk({tag, "_c_w_en"}, c_w_en, 1'b0);
        chk({tag, "_c_y_valid"}, c_y_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; start_c = 1'b0; x_we = 1'b0; y_ready = 1'b0; clr = 1'b1;
        x_addr = '0; x_wdata = '0;
        tick(); tick(); tick();
        check_idle_outputs("reset");
        rst = 1'b1; clr = 1'b0;
        tick();

        // Basic case: x = 1.0, weights 1..4 then -1.0 x4.
        for (int i = 0; i < NS; i++) begin xs[i] = 16'sh0100; write_x(10'(i), 16'h0100); end
        wmem_s = '{16'sh0100, 16'sh0200, 16'sh0300, 16'sh0400,
                   -16'sh0100, -16'sh0100, -16'sh0100, -16'sh0100};
        run_small(0, 1'b0);
        check_small("basic");
        if (res_a.size() == OS) begin
            chk("basic_a_n0_value", res_a[0], 16'h0A00);
            chk("basic_a_n1_value", res_a[1], 16'hFC00);
            chk("basic_b_n1_relu", res_b[1], 16'h0000);
        end

        // Back-pressure: hold y_ready low for 10 cycles on the first result.
        run_small(10, 1'b0);
        check_small("stall");
        chk("stall_hold_violations", stall_err, 0);

        // Reset during the second neuron's accumulation.
        clr = 1'b1; tick(); clr = 1'b0;
        y_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        begin
            bit found = 1'b0;
            int wen_after = 0;
            for (int k = 0; k < 40 && !found; k++) begin
                if (a_w_en && a_y_idx == 8'd1) found = 1'b1;
                else tick();
            end
            chk("rst_reached_acc2", found, 1'b1);
            rst = 1'b0; tick(); rst = 1'b1;
            check_idle_outputs("midrst");
            for (int k = 0; k < 10; k++) begin
                if (a_w_en) wen_after++;
                tick();
            end
            chk("midrst_wen_after", wen_after, 0);
            chk("midrst_no_done", done_a, 0);
        end

        // Out-of-range writes are dropped; a write while busy is dropped;
        // the activation buffer survives reset.
        write_x(10'd4, 16'h7FFF);
        write_x(10'd1023, 16'h7FFF);
        run_small(0, 1'b1);
        check_small("restart");

        // Saturation: both rails.
        for (int i = 0; i < NS; i++) begin xs[i] = 16'sh7FFF; write_x(10'(i), 16'h7FFF); end
        wmem_s = '{16'sh7FFF, 16'sh7FFF, 16'sh7FFF, 16'sh7FFF,
                   shortint'(16'h8000), shortint'(16'h8000), shortint'(16'h8000), shortint'(16'h8000)};
        run_small(0, 1'b0);
        check_small("sat");
        if (res_a.size() == OS) begin
            chk("sat_a_pos_rail", res_a[0], 16'h7FFF);
            chk("sat_a_neg_rail", res_a[1], 16'h8000);
            chk("sat_b_neg_relu", res_b[1], 16'h0000);
        end

        // Larger layer, random data, random back-pressure.
        for (int i = 0; i < NC; i++) begin
            xc[i] = shortint'(int'($urandom_range(0, 1023)) - 512);
            write_x(10'(i), xc[i]);
        end
        for (int k = 0; k < NC*OC; k++) wmem_c[k] = shortint'(int'($urandom_range(0, 2047)) - 1024);
        clr = 1'b1; tick(); clr = 1'b0;
        start_c = 1'b1; tick(); start_c = 1'b0;
        begin
            int got = 0;
            bit fin = 1'b0;
            for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
                y_ready = ($urandom_range(0, 3) != 0);
                if (c_y_valid && y_ready) begin
                    chk($sformatf("big_idx%0d", got), c_y_idx, 8'(got));
                    chk($sformatf("big_data%0d", got), c_y_data, ref_out(dot_c(got), 1'b0));
                    got++;
                end
                if (c_done) fin = 1'b1;
                tick();
            end
            tick(); tick();
            chk("big_done_seen", fin, 1'b1);
            chk("big_n_results", got, OC);
            chk("big_wen_total", wen_c, NC*OC);
            chk("big_done_count", done_c, 1);
            chk("big_busy_end", c_busy, 1'b0);
            chk("big_idx_back_to_0", c_y_idx, 8'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
